// File: rtl/block_packer_if.sv
// Word-in / block-out stream bundle for the ASCON block packer.
// The master drives words and block-ready; the slave drives in_ready and the block.
interface block_packer_if;
    localparam int unsigned WORD_W = 32;
    localparam int unsigned BLK_W  = 128;
    localparam int unsigned NB_W   = 5;

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              in_last;
    logic [2:0]        in_bytes;
    logic              blk_valid;
    logic              blk_ready;
    logic [BLK_W-1:0]  blk_data;
    logic              blk_last;
    logic [NB_W-1:0]   blk_nbytes;

    modport master (
        output in_valid, in_data, in_last, in_bytes, blk_ready,
        input  in_ready, blk_valid, blk_data, blk_last, blk_nbytes
    );

    modport slave (
        input  in_valid, in_data, in_last, in_bytes, blk_ready,
        output in_ready, blk_valid, blk_data, blk_last, blk_nbytes
    );
endinterface

// File: rtl/block_packer.sv
// Packs little-endian 32-bit words into 128-bit ASCON-AEAD128 rate blocks and
// applies 0x01 padding to the final block, emitting a padding-only block when needed.
module block_packer (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    block_packer_if.slave bus
);
    localparam int unsigned WORD_W = 32;
    localparam int unsigned BLK_W  = 128;
    localparam int unsigned NB_W   = 5;

    typedef enum logic [1:0] {
        S_FILL    = 2'd0,
        S_OUT     = 2'd1,
        S_PAD_OUT = 2'd2
    } state_t;

    state_t            r_state, w_state_nxt;
    logic [BLK_W-1:0]  r_buf, w_buf_nxt;
    logic [1:0]        r_wcnt, w_wcnt_nxt;
    logic              r_last, w_last_nxt;
    logic [NB_W-1:0]   r_nbytes, w_nbytes_nxt;
    logic              r_pad, w_pad_nxt;

    logic              w_xfer;
    logic [2:0]        w_nb;
    logic [NB_W-1:0]   w_n;
    logic [WORD_W-1:0] w_word;
    logic [BLK_W-1:0]  w_word_sh;
    logic [BLK_W-1:0]  w_pad_sh;

    assign bus.in_ready   = (r_state == S_FILL) && !clr;
    assign w_xfer         = bus.in_valid && bus.in_ready;
    assign bus.blk_valid  = (r_state != S_FILL);
    assign bus.blk_data   = r_buf;
    assign bus.blk_last   = r_last;
    assign bus.blk_nbytes = r_nbytes;

    // Valid byte count of this word: 4 unless last, clamped to 4
    assign w_nb = !bus.in_last ? 3'd4 : ((bus.in_bytes > 3'd4) ? 3'd4 : bus.in_bytes);
    assign w_n  = NB_W'({r_wcnt, 2'b00}) + NB_W'(w_nb);

    // Zero bytes beyond the valid count
    always_comb begin
        w_word = '0;
        for (int b = 0; b < 4; b++) begin
            if (3'(b) < w_nb) begin
                w_word[8*b +: 8] = bus.in_data[8*b +: 8];
            end
        end
    end

    assign w_word_sh = BLK_W'(w_word) << {r_wcnt, 5'b00000};
    assign w_pad_sh  = BLK_W'(8'h01) << {w_n, 3'b000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_FILL;
            r_buf    <= '0;
            r_wcnt   <= '0;
            r_last   <= 1'b0;
            r_nbytes <= '0;
            r_pad    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_buf    <= w_buf_nxt;
            r_wcnt   <= w_wcnt_nxt;
            r_last   <= w_last_nxt;
            r_nbytes <= w_nbytes_nxt;
            r_pad    <= w_pad_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_buf_nxt    = r_buf;
        w_wcnt_nxt   = r_wcnt;
        w_last_nxt   = r_last;
        w_nbytes_nxt = r_nbytes;
        w_pad_nxt    = r_pad;

        if (clr) begin
            w_state_nxt  = S_FILL;
            w_buf_nxt    = '0;
            w_wcnt_nxt   = '0;
            w_last_nxt   = 1'b0;
            w_nbytes_nxt = '0;
            w_pad_nxt    = 1'b0;
        end else begin
            case (r_state)
                S_FILL: begin
                    if (w_xfer) begin
                        w_buf_nxt = r_buf | w_word_sh;
                        if (bus.in_last) begin
                            w_state_nxt = S_OUT;
                            w_wcnt_nxt  = '0;
                            if (w_n < NB_W'(16)) begin
                                w_buf_nxt    = r_buf | w_word_sh | w_pad_sh;
                                w_last_nxt   = 1'b1;
                                w_nbytes_nxt = w_n;
                            end else begin
                                // Message ends on a block boundary: padding goes in its own block
                                w_last_nxt   = 1'b0;
                                w_nbytes_nxt = NB_W'(16);
                                w_pad_nxt    = 1'b1;
                            end
                        end else if (r_wcnt == 2'd3) begin
                            w_state_nxt  = S_OUT;
                            w_wcnt_nxt   = '0;
                            w_last_nxt   = 1'b0;
                            w_nbytes_nxt = NB_W'(16);
                        end else begin
                            w_wcnt_nxt = r_wcnt + 2'd1;
                        end
                    end
                end
                S_OUT: begin
                    if (bus.blk_ready) begin
                        if (r_pad) begin
                            w_state_nxt  = S_PAD_OUT;
                            w_buf_nxt    = BLK_W'(1);
                            w_last_nxt   = 1'b1;
                            w_nbytes_nxt = '0;
                            w_pad_nxt    = 1'b0;
                        end else begin
                            w_state_nxt  = S_FILL;
                            w_buf_nxt    = '0;
                            w_last_nxt   = 1'b0;
                            w_nbytes_nxt = '0;
                        end
                    end
                end
                S_PAD_OUT: begin
                    if (bus.blk_ready) begin
                        w_state_nxt  = S_FILL;
                        w_buf_nxt    = '0;
                        w_last_nxt   = 1'b0;
                        w_nbytes_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt = S_FILL;
                end
            endcase
        end
    end
endmodule

// File: doc/block_packer.md
BLOCK_PACKER -- requirements
Module: block_packer

Interface
REQ-001 Parameter: none; input word width fixed at 32 bits, output block width fixed at 128 bits (ASCON-AEAD128 rate).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 clr  input  1  synchronous clear; discards partial block, returns to FILL.
REQ-005 in_valid  input  1  upstream word present.
REQ-006 in_ready  output  1  block accepts a word this cycle.
REQ-007 in_data  input  32  input word, little-endian bytes (in_data[7:0] = first byte).
REQ-008 in_last  input  1  word is final word of the message.
REQ-009 in_bytes  input  3  valid byte count 0..4; sampled only when in_last=1, else treated as 4.
REQ-010 blk_valid  output  1  output block present.
REQ-011 blk_ready  input  1  downstream (enable-register stage) accepts block.
REQ-012 blk_data  output  128  assembled/padded block; word k occupies bits [32k+31:32k].
REQ-013 blk_last  output  1  block is final (padded) block of message.
REQ-014 blk_nbytes  output  5  data bytes in block, 0..16.

Function
REQ-015 States: FILL (collect words), OUT (present data block), PAD_OUT (present padding-only block).
REQ-016 in_ready = 1 iff state FILL and clr=0; transfer = in_valid & in_ready.
REQ-017 Word counter wcnt (2 bits) selects destination word slot; increments per transfer, reset to 0 on block completion, clr, reset.
REQ-018 Bytes at positions >= in_bytes of a last word are written as 0x00 regardless of in_data.
REQ-019 Transfer with in_last=0 and wcnt=3: go OUT, blk_last=0, blk_nbytes=16.
REQ-020 Transfer with in_last=1: n = 4*wcnt + in_bytes; if n<16, byte n of block set to 0x01, all higher bytes 0x00, go OUT with blk_last=1, blk_nbytes=n.
REQ-021 Transfer with in_last=1 and n=16: go OUT with blk_last=0, blk_nbytes=16; after that handshake go PAD_OUT.
REQ-022 PAD_OUT presents blk_data=128'h1, blk_last=1, blk_nbytes=0.
REQ-023 in_last=1 with in_bytes=0 at wcnt=0 (empty message or tail) yields blk_data=128'h1, blk_last=1, blk_nbytes=0 from OUT.
REQ-024 in_bytes>4 with in_last=1 is clamped to 4.
REQ-025 blk_valid=1 in OUT and PAD_OUT; asserted first cycle after completing transfer (latency 1).
REQ-026 blk_data, blk_last, blk_nbytes stable while blk_valid=1 and blk_ready=0.
REQ-027 Handshake blk_valid & blk_ready: OUT->FILL (or PAD_OUT per REQ-021), PAD_OUT->FILL; block buffer cleared to 0 on exit.
REQ-028 clr=1 in any state: next state FILL, buffer and wcnt zeroed, blk_valid=0 next cycle; clr has priority over transfers and handshakes.
REQ-029 blk_ready ignored when blk_valid=0; in_valid ignored when in_ready=0.

Reset
REQ-030 rst_n=0 asynchronously forces state FILL, wcnt=0, buffer 0, blk_valid=0, blk_last=0, blk_nbytes=0, blk_data=0; in_ready=1 (FILL, clr=0).
REQ-031 Reset mid-block discards all collected words; no block emitted for them.

Verification
REQ-032 Four full words 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, in_last=0 -> next cycle blk_valid=1, blk_data=0x0F0E..0100, blk_last=0, blk_nbytes=16.
REQ-033 Two words, second in_last=1 in_bytes=3 data 0xFFCCBBAA -> blk_data[63:32]=0x01CCBBAA, bits[127:64]=0, blk_last=1, blk_nbytes=7.
REQ-034 Four words, fourth in_last=1 in_bytes=4 -> full block blk_last=0, then after handshake blk_data=128'h1, blk_last=1, blk_nbytes=0.
REQ-035 Single word in_last=1 in_bytes=0 -> blk_data=128'h1, blk_last=1, blk_nbytes=0.
REQ-036 blk_ready held 0 for 10 cycles in OUT -> outputs stable, in_ready=0, in_valid words not accepted; clr pulse then -> blk_valid=0, in_ready=1.
REQ-037 rst_n low after 2 words, then 4 new words -> emitted block contains only the new words.
